// File: rtl/key_debounce_pkg.sv
// ============================================================================
// Module  : key_debounce_pkg
// Brief   : Shared state encoding and counter-width helper for key_debounce.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package key_debounce_pkg;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_db_dn = 2'd1;
  localparam logic [1:0] c_held  = 2'd2;
  localparam logic [1:0] c_db_up = 2'd3;

  // A counter must be at least one bit wide even for tiny parameter values.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
// Module  : key_debounce_ch
// Brief   : One key channel: 2-flop synchronizer, debounce FSM, long-press timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LONG_CYCLES     = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DBW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW  = cnt_width(LONG_CYCLES);

  logic [1:0]     r_sync;
  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [DBW-1:0] r_db_cnt;
  logic [HW-1:0]  r_hold_cnt;
  logic           r_long_done;
  logic           r_press;
  logic           r_release;
  logic           r_long;
  logic           w_key;
  logic           w_db_done;
  logic           w_hold_top;
  logic           w_press;
  logic           w_release;
  logic           w_long;
  logic           w_level;

  assign w_key      = r_sync[1];
  assign w_db_done  = (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign w_hold_top = (r_hold_cnt == HW'(LONG_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync      <= 2'b11;
      r_state     <= c_idle;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], key_ni};
      r_state   <= w_state_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;

      if (w_state_nxt != r_state)
        r_db_cnt <= '0;
      else if ((r_state == c_db_dn || r_state == c_db_up) && !w_db_done)
        r_db_cnt <= r_db_cnt + DBW'(1);

      // The hold count still advances on the cycle HELD is left, and stays frozen in DB_UP.
      if (w_press)
        r_hold_cnt <= '0;
      else if (r_state == c_held && !w_hold_top)
        r_hold_cnt <= r_hold_cnt + HW'(1);

      if (w_release)
        r_long_done <= 1'b0;
      else if (w_long)
        r_long_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (!w_key) w_state_nxt = c_db_dn;
      c_db_dn: if (w_key) w_state_nxt = c_idle;
               else if (w_db_done) w_state_nxt = c_held;
      c_held:  if (w_key) w_state_nxt = c_db_up;
      c_db_up: if (!w_key) w_state_nxt = c_held;
               else if (w_db_done) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_press   = (r_state == c_db_dn) && !w_key && w_db_done;
    w_release = (r_state == c_db_up) && w_key && w_db_done;
    w_long    = (r_state == c_held) && w_hold_top && !r_long_done;
    w_level   = (r_state == c_held) || (r_state == c_db_up);
  end

  assign level_o   = w_level;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign long_o    = r_long;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module  : key_debounce
// Brief   : N_KEYS independent debounced push-button channels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LONG_CYCLES     = 25_000_000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_KEYS-1:0] key_ni,
  output logic [N_KEYS-1:0] level_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] long_o
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .key_ni   (key_ni[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// Module  : tb_key_debounce
// Brief   : Directed self-checking bench, DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [1:0] key_ni;
  logic [1:0] level_o;
  logic [1:0] press_o;
  logic [1:0] release_o;
  logic [1:0] long_o;

  int total = 0;
  int bad   = 0;

  key_debounce #(
    .N_KEYS         (2),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .key_ni   (key_ni),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o)
  );

  always #5 clk_i = ~clk_i;

  // Packed observation vector: {level, press, release, long}
  function automatic logic [7:0] pack(input logic [1:0] l, input logic [1:0] p,
                                      input logic [1:0] r, input logic [1:0] g);
    return {l, p, r, g};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n_i = 1'b0;
    key_ni  = 2'b11;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst_n_i = 1'b1;
      tick();
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== 8'h00) begin
        bad++;
        $display("FAIL reset c=%0d got=%b exp=%b", c, got, 8'h00);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] got, exp;
    key_ni = 2'b10;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp = pack({1'b0, c >= 6}, {1'b0, c == 6}, 2'b00, 2'b00);
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL clean_press c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    key_ni = 2'b11;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp = pack({1'b0, c < 6}, 2'b00, {1'b0, c == 6}, 2'b00);
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL clean_release c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] got;
    key_ni = 2'b10;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) key_ni = 2'b11;
      tick();
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== 8'h00) begin
        bad++;
        $display("FAIL glitch c=%0d got=%b exp=%b", c, got, 8'h00);
      end
    end
  endtask

  task automatic test_long_press();
    logic [7:0] got, exp;
    key_ni = 2'b10;
    for (int c = 0; c < 42; c++) begin
      if (c == 30) key_ni = 2'b11;
      tick();
      exp = pack({1'b0, c >= 6 && c < 36}, {1'b0, c == 6},
                 {1'b0, c == 36}, {1'b0, c == 22});
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL long_press c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [7:0] got, exp;
    key_ni = 2'b10;
    for (int c = 0; c < 52; c++) begin
      if (c == 10) key_ni = 2'b11;
      if (c == 12) key_ni = 2'b10;
      if (c == 40) key_ni = 2'b11;
      tick();
      exp = pack({1'b0, c >= 6 && c < 46}, {1'b0, c == 6},
                 {1'b0, c == 46}, {1'b0, c == 24});
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL release_bounce c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [7:0] got, exp;
    key_ni = 2'b10;
    for (int c = 0; c < 26; c++) begin
      if (c == 10) begin
        rst_n_i = 1'b0;
        #1;
        got = {level_o, press_o, release_o, long_o};
        total++;
        if (got !== 8'h00) begin
          bad++;
          $display("FAIL reset_async got=%b exp=%b", got, 8'h00);
        end
      end
      if (c == 13) rst_n_i = 1'b1;
      tick();
      exp = pack({1'b0, (c >= 6 && c < 10) || c >= 19},
                 {1'b0, c == 6 || c == 19}, 2'b00, 2'b00);
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid_press c=%0d got=%b exp=%b", c, got, exp);
      end
    end
    key_ni = 2'b11;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp = pack({1'b0, c < 6}, 2'b00, {1'b0, c == 6}, 2'b00);
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_after_release c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, exp;
    key_ni = 2'b00;
    for (int c = 0; c < 18; c++) begin
      if (c == 9) key_ni = 2'b11;
      tick();
      exp = pack((c >= 6 && c < 15) ? 2'b11 : 2'b00,
                 (c == 6) ? 2'b11 : 2'b00,
                 (c == 15) ? 2'b11 : 2'b00, 2'b00);
      got = {level_o, press_o, release_o, long_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL simultaneous c=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_reset_mid_press();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
